// File: rtl/latch_bus_pkg.sv
// Shared definitions for controllers that sequence transfers over the latch array bus.
package latch_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } bus_state_e;

  // LE hold counter; wide enough for LE_CYCLES up to 15
  localparam int CNT_W = 4;

  function automatic int idx_width(input int n_latch);
    return (n_latch > 1) ? $clog2(n_latch) : 1;
  endfunction

endpackage

// File: rtl/latch_bus_sequencer_if.sv
// Request/strobe bundle between requesters, the sequencer and the latch array.
interface latch_bus_sequencer_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LATCH = 8,
  parameter int IDX_W     = 4
);
  logic [NUM_REQ-1:0]       REQ;
  logic [NUM_REQ*IDX_W-1:0] SRC;
  logic [NUM_REQ*IDX_W-1:0] DST;
  logic [NUM_REQ-1:0]       ACK;
  logic                     ERR;
  logic                     BUSY;
  logic [NUM_LATCH-1:0]     nOE;
  logic [NUM_LATCH-1:0]     LE;

  modport master (output REQ, SRC, DST, input ACK, ERR, BUSY, nOE, LE);
  modport slave  (input REQ, SRC, DST, output ACK, ERR, BUSY, nOE, LE);
endinterface

// File: rtl/latch_bus_sequencer_rr_arbiter.sv
// Combinational round-robin grant: first set request at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [PTR_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  always_comb begin
    int j;
    logic [PTR_W-1:0] jj;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = PTR_W'(j);
      if (!gnt_vld_o && req_i[jj]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = jj;
      end
    end
  end

endmodule

// File: rtl/latch_bus_sequencer.sv
// Round-robin sequencer for latch-to-latch transfers on a shared tri-state bus.
module latch_bus_sequencer
  import latch_bus_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LATCH = 8,
  parameter int IDX_W     = 4,
  parameter int LE_CYCLES = 2
) (
  input logic CLK,
  input logic nRST,
  latch_bus_sequencer_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (IDX_W < idx_width(NUM_LATCH)) begin : g_bad_idx_w
    $error("IDX_W too narrow for NUM_LATCH");
  end

  bus_state_e           state_q;
  logic [PTR_W-1:0]     ptr_q, ptr_d, grant_q, gnt_idx;
  logic                 gnt_vld, req_bad;
  logic [IDX_W-1:0]     src_q, dst_q, src_sel, dst_sel;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_LATCH-1:0] noe_q, le_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 err_q, busy_q;

  function automatic logic [NUM_LATCH-1:0] latch_onehot(input logic [IDX_W-1:0] idx);
    latch_onehot = '0;
    for (int i = 0; i < NUM_LATCH; i++)
      if (idx == IDX_W'(i)) latch_onehot[i] = 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [PTR_W-1:0] idx);
    req_onehot = '0;
    for (int r = 0; r < NUM_REQ; r++)
      if (idx == PTR_W'(r)) req_onehot[r] = 1'b1;
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i    (bus.REQ),
    .ptr_i    (ptr_q),
    .gnt_idx_o(gnt_idx),
    .gnt_vld_o(gnt_vld)
  );

  always_comb begin
    src_sel = '0;
    dst_sel = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt_idx == PTR_W'(r)) begin
        src_sel = bus.SRC[r*IDX_W +: IDX_W];
        dst_sel = bus.DST[r*IDX_W +: IDX_W];
      end
    end
    // Out-of-range indices are rejected here so no strobe ever targets a missing latch
    req_bad = (src_sel == dst_sel) || (int'(src_sel) >= NUM_LATCH) ||
              (int'(dst_sel) >= NUM_LATCH);
    ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      noe_q   <= '1;
      le_q    <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            grant_q <= gnt_idx;
            src_q   <= src_sel;
            dst_q   <= dst_sel;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            if (req_bad) begin
              state_q <= ST_RELEASE;
              ack_q   <= req_onehot(gnt_idx);
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_DRIVE;
              noe_q   <= ~latch_onehot(src_sel);
            end
          end
        end
        ST_DRIVE: begin
          state_q <= ST_LATCH;
          le_q    <= latch_onehot(dst_q);
          cnt_q   <= CNT_W'(LE_CYCLES - 1);
        end
        ST_LATCH: begin
          if (cnt_q == '0) begin
            state_q <= ST_HOLD;
            le_q    <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        // Outputs are registered on entry, so RELEASE values are set leaving HOLD
        ST_HOLD: begin
          state_q <= ST_RELEASE;
          noe_q   <= '1;
          ack_q   <= req_onehot(grant_q);
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          noe_q   <= '1;
          le_q    <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ACK  = ack_q;
  assign bus.ERR  = err_q;
  assign bus.BUSY = busy_q;
  assign bus.nOE  = noe_q;
  assign bus.LE   = le_q;

endmodule

// File: tb/tb_latch_bus_sequencer.sv
// Bench for latch_bus_sequencer: scoreboard of expected ACKs plus a 74HC373 array model.
module tb_latch_bus_sequencer;

  localparam int N = 4;
  localparam int L = 8;
  localparam int W = 4;
  localparam int LE_MAIN = 2;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  latch_bus_sequencer_if #(.NUM_REQ(N), .NUM_LATCH(L), .IDX_W(W)) bus_if ();
  latch_bus_sequencer_if #(.NUM_REQ(N), .NUM_LATCH(L), .IDX_W(W)) bus1_if ();
  latch_bus_sequencer_if #(.NUM_REQ(N), .NUM_LATCH(L), .IDX_W(W)) bus15_if ();

  latch_bus_sequencer #(.NUM_REQ(N), .NUM_LATCH(L), .IDX_W(W), .LE_CYCLES(LE_MAIN)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus_if));
  latch_bus_sequencer #(.NUM_REQ(N), .NUM_LATCH(L), .IDX_W(W), .LE_CYCLES(1)) dut1 (
    .CLK(CLK), .nRST(nRST), .bus(bus1_if));
  latch_bus_sequencer #(.NUM_REQ(N), .NUM_LATCH(L), .IDX_W(W), .LE_CYCLES(15)) dut15 (
    .CLK(CLK), .nRST(nRST), .bus(bus15_if));

  // 74HC373 array model on the main DUT's bus
  logic [7:0] lat [0:L-1];
  logic [7:0] bus_val;
  logic       lat_reload = 1'b0;
  logic [7:0] lat_seed = 8'h00;

  always_comb begin
    bus_val = 8'hxx;
    for (int i = 0; i < L; i++)
      if (!bus_if.nOE[i]) bus_val = lat[i];
  end

  always @(posedge CLK) begin
    for (int i = 0; i < L; i++) begin
      if (lat_reload) lat[i] <= 8'(int'(lat_seed) + i * 37 + 1);
      else if (bus_if.LE[i]) lat[i] <= bus_val;
    end
  end

  typedef struct {
    int         req;
    bit         err;
    int         src;
    int         dst;
    logic [7:0] data;
  } exp_t;

  exp_t       sb [$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         m_ptr = 0;
  int         noe_n = 0;
  int         le_n = 0;
  bit         bad_idx = 0;
  logic [7:0] prev_noe = 8'hFF;

  task automatic push(input int r, input bit e, input int s, input int d);
    exp_t x;
    x.req = r; x.err = e; x.src = s; x.dst = d;
    x.data = (s < L) ? lat[3'(s)] : 8'hxx;
    sb.push_back(x);
  endtask

  task automatic reload_lat(input logic [7:0] seed);
    lat_seed = seed;
    lat_reload = 1'b1;
    tick();
    lat_reload = 1'b0;
  endtask

  // One clock: invariant monitor and scoreboard pop on ACK
  task automatic tick();
    exp_t e;
    int   exp_n;
    @(negedge CLK);
    cyc++;
    n_cmp++;
    if ($countones(~bus_if.nOE) > 1 || $countones(bus_if.LE) > 1 ||
        (bus_if.LE != '0 && prev_noe == 8'hFF)) begin
      n_fail++;
      $display("FAIL invariant cyc=%0d nOE=%b LE=%b prev_nOE=%b required one-hot with nOE ahead of LE",
               cyc, bus_if.nOE, bus_if.LE, prev_noe);
    end
    prev_noe = bus_if.nOE;
    if (!nRST) begin
      sb.delete();
      noe_n = 0; le_n = 0; bad_idx = 0;
    end else begin
      if (bus_if.nOE != 8'hFF) begin
        noe_n++;
        if (sb.size() == 0 || bus_if.nOE !== ~(8'b1 << sb[0].src)) bad_idx = 1;
      end
      if (bus_if.LE != '0) begin
        le_n++;
        if (sb.size() == 0 || bus_if.LE !== (8'b1 << sb[0].dst)) bad_idx = 1;
      end
      if (bus_if.ACK != '0) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_ack cyc=%0d ACK=%b required no ACK", cyc, bus_if.ACK);
        end else begin
          e = sb.pop_front();
          if (bus_if.ACK !== 4'(1 << e.req) || bus_if.ERR !== e.err) begin
            n_fail++;
            $display("FAIL sb_ack cyc=%0d ACK=%b ERR=%b required ACK=%b ERR=%b",
                     cyc, bus_if.ACK, bus_if.ERR, 4'(1 << e.req), e.err);
          end
          n_cmp++;
          exp_n = e.err ? 0 : LE_MAIN;
          if (noe_n != (e.err ? 0 : LE_MAIN + 2) || le_n != exp_n || bad_idx) begin
            n_fail++;
            $display("FAIL sb_strobes cyc=%0d nOE_cycles=%0d LE_cycles=%0d wrong_idx=%0d required %0d/%0d/0",
                     cyc, noe_n, le_n, bad_idx, e.err ? 0 : LE_MAIN + 2, exp_n);
          end
          if (!e.err) begin
            n_cmp++;
            if (lat[3'(e.dst)] !== e.data) begin
              n_fail++;
              $display("FAIL sb_latch_data cyc=%0d latch%0d=%h required %h",
                       cyc, e.dst, lat[3'(e.dst)], e.data);
            end
          end
        end
        noe_n = 0; le_n = 0; bad_idx = 0;
      end
    end
  endtask

  task automatic test_reset();
    bus_if.REQ = '0; bus_if.SRC = '0; bus_if.DST = '0;
    bus1_if.REQ = '0; bus1_if.SRC = '0; bus1_if.DST = '0;
    bus15_if.REQ = '0; bus15_if.SRC = '0; bus15_if.DST = '0;
    nRST = 1'b0;
    reload_lat(8'h10);
    tick();
    n_cmp += 5;
    if (bus_if.nOE !== 8'hFF) begin n_fail++; $display("FAIL reset_nOE got %b want 11111111", bus_if.nOE); end
    if (bus_if.LE !== 8'h00) begin n_fail++; $display("FAIL reset_LE got %b want 00000000", bus_if.LE); end
    if (bus_if.ACK !== 4'h0) begin n_fail++; $display("FAIL reset_ACK got %b want 0000", bus_if.ACK); end
    if (bus_if.ERR !== 1'b0) begin n_fail++; $display("FAIL reset_ERR got %b want 0", bus_if.ERR); end
    if (bus_if.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_BUSY got %b want 0", bus_if.BUSY); end
    nRST = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_contention();
    int nack, last;
    reload_lat(8'h20);
    for (int r = 0; r < N; r++) begin
      bus_if.SRC[r*W +: W] = 4'(r);
      bus_if.DST[r*W +: W] = 4'(r + 4);
    end
    for (int t = 0; t < 5; t++) begin
      push(m_ptr, 1'b0, m_ptr, m_ptr + 4);
      m_ptr = (m_ptr + 1) % N;
    end
    bus_if.REQ = 4'b1111;
    nack = 0; last = 0;
    for (int k = 1; k <= 60 && nack < 5; k++) begin
      tick();
      if (bus_if.ACK != '0) begin
        nack++;
        n_cmp++;
        if (k - last != ((nack == 1) ? LE_MAIN + 3 : LE_MAIN + 4)) begin
          n_fail++;
          $display("FAIL contention_spacing ack#%0d after %0d cycles want %0d",
                   nack, k - last, (nack == 1) ? LE_MAIN + 3 : LE_MAIN + 4);
        end
        last = k;
        if (nack == 5) bus_if.REQ = '0;
      end
    end
    n_cmp++;
    if (nack != 5) begin n_fail++; $display("FAIL contention_ack_count got %0d want 5", nack); bus_if.REQ = '0; end
    tick();
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL contention_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_single();
    logic [7:0] en;
    logic [7:0] el;
    reload_lat(8'h30);
    bus_if.SRC[0 +: W] = 4'd3;
    bus_if.DST[0 +: W] = 4'd5;
    push(0, 1'b0, 3, 5);
    m_ptr = 1;
    bus_if.REQ = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      en = (k >= 1 && k <= 4) ? 8'b1111_0111 : 8'hFF;
      el = (k == 2 || k == 3) ? 8'b0010_0000 : 8'h00;
      n_cmp += 4;
      if (bus_if.nOE !== en) begin n_fail++; $display("FAIL single_nOE c%0d got %b want %b", k, bus_if.nOE, en); end
      if (bus_if.LE !== el) begin n_fail++; $display("FAIL single_LE c%0d got %b want %b", k, bus_if.LE, el); end
      if (bus_if.ACK !== ((k == 5) ? 4'b0001 : 4'b0000) || bus_if.ERR !== 1'b0) begin
        n_fail++; $display("FAIL single_ACK c%0d got %b/%b want %b/0", k, bus_if.ACK, bus_if.ERR, (k == 5) ? 4'b0001 : 4'b0000);
      end
      if (bus_if.BUSY !== (k <= 5)) begin n_fail++; $display("FAIL single_BUSY c%0d got %b want %b", k, bus_if.BUSY, k <= 5); end
      if (k == 5) bus_if.REQ = '0;
    end
  endtask

  task automatic test_error();
    for (int t = 0; t < 2; t++) begin
      bus_if.SRC[2*W +: W] = (t == 0) ? 4'd6 : 4'd9;
      bus_if.DST[2*W +: W] = (t == 0) ? 4'd6 : 4'd1;
      push(2, 1'b1, (t == 0) ? 6 : 9, (t == 0) ? 6 : 1);
      m_ptr = 3;
      bus_if.REQ = 4'b0100;
      for (int k = 1; k <= 2; k++) begin
        tick();
        n_cmp += 3;
        if (bus_if.ACK !== ((k == 1) ? 4'b0100 : 4'b0000) || bus_if.ERR !== (k == 1)) begin
          n_fail++; $display("FAIL error%0d_ACK c%0d got %b/%b want %b/%b", t, k, bus_if.ACK, bus_if.ERR,
                             (k == 1) ? 4'b0100 : 4'b0000, k == 1);
        end
        if (bus_if.nOE !== 8'hFF || bus_if.LE !== 8'h00) begin
          n_fail++; $display("FAIL error%0d_strobes c%0d got nOE=%b LE=%b want 11111111/00000000", t, k, bus_if.nOE, bus_if.LE);
        end
        if (bus_if.BUSY !== (k == 1)) begin n_fail++; $display("FAIL error%0d_BUSY c%0d got %b want %b", t, k, bus_if.BUSY, k == 1); end
        if (k == 1) bus_if.REQ = '0;
      end
    end
  endtask

  task automatic test_input_change();
    logic [7:0] en;
    logic [7:0] el;
    reload_lat(8'h40);
    bus_if.SRC[0 +: W] = 4'd1;
    bus_if.DST[0 +: W] = 4'd2;
    push(0, 1'b0, 1, 2);
    m_ptr = 1;
    bus_if.REQ = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      en = (k >= 1 && k <= 4) ? 8'b1111_1101 : 8'hFF;
      el = (k == 2 || k == 3) ? 8'b0000_0100 : 8'h00;
      n_cmp += 3;
      if (bus_if.nOE !== en) begin n_fail++; $display("FAIL chg_nOE c%0d got %b want %b", k, bus_if.nOE, en); end
      if (bus_if.LE !== el) begin n_fail++; $display("FAIL chg_LE c%0d got %b want %b", k, bus_if.LE, el); end
      if (bus_if.ACK !== ((k == 5) ? 4'b0001 : 4'b0000)) begin
        n_fail++; $display("FAIL chg_ACK c%0d got %b want %b", k, bus_if.ACK, (k == 5) ? 4'b0001 : 4'b0000);
      end
      if (k == 2) begin
        bus_if.SRC[0 +: W] = 4'd4;
        bus_if.DST[0 +: W] = 4'd7;
        bus_if.REQ = '0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int ackc;
    reload_lat(8'h50);
    bus_if.SRC[0 +: W] = 4'd2;
    bus_if.DST[0 +: W] = 4'd6;
    push(0, 1'b0, 2, 6);
    bus_if.REQ = 4'b0001;
    tick();
    tick();
    n_cmp++;
    if (bus_if.LE !== 8'b0100_0000) begin n_fail++; $display("FAIL rstmid_pre_LE got %b want 01000000", bus_if.LE); end
    nRST = 1'b0;
    #1;
    n_cmp += 2;
    if (bus_if.nOE !== 8'hFF || bus_if.LE !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_async got nOE=%b LE=%b want 11111111/00000000", bus_if.nOE, bus_if.LE);
    end
    if (bus_if.ACK !== 4'h0 || bus_if.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctl got ACK=%b BUSY=%b want 0000/0", bus_if.ACK, bus_if.BUSY);
    end
    bus_if.REQ = '0;
    m_ptr = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (bus_if.ACK !== 4'h0) begin n_fail++; $display("FAIL rstmid_noack got %b want 0000", bus_if.ACK); end
    end
    nRST = 1'b1;
    tick();
    bus_if.SRC[0 +: W] = 4'd0; bus_if.DST[0 +: W] = 4'd3;
    bus_if.SRC[W +: W] = 4'd1; bus_if.DST[W +: W] = 4'd4;
    push(m_ptr, 1'b0, m_ptr, m_ptr + 3);
    m_ptr = (m_ptr + 1) % N;
    bus_if.REQ = 4'b0011;
    ackc = 0;
    for (int k = 1; k <= 20 && ackc == 0; k++) begin
      tick();
      if (bus_if.ACK != '0) begin
        ackc = k;
        bus_if.REQ = '0;
        n_cmp++;
        if (bus_if.ACK !== 4'b0001) begin n_fail++; $display("FAIL rstmid_grant got %b want 0001", bus_if.ACK); end
      end
    end
    n_cmp++;
    if (ackc != LE_MAIN + 3) begin n_fail++; $display("FAIL rstmid_latency got %0d want %0d", ackc, LE_MAIN + 3); end
  endtask

  task automatic test_le_cycles();
    int le1, le15, noe1, noe15, ack1, ack15, na1, na15;
    le1 = 0; le15 = 0; noe1 = 0; noe15 = 0; ack1 = 0; ack15 = 0; na1 = 0; na15 = 0;
    bus1_if.SRC[0 +: W] = 4'd3;  bus1_if.DST[0 +: W] = 4'd5;
    bus15_if.SRC[0 +: W] = 4'd3; bus15_if.DST[0 +: W] = 4'd5;
    bus1_if.REQ = 4'b0001;
    bus15_if.REQ = 4'b0001;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (bus1_if.LE[5]) le1++;
      if (!bus1_if.nOE[3]) noe1++;
      if (bus1_if.ACK[0]) begin ack1 = k; na1++; bus1_if.REQ = '0; end
      if (bus15_if.LE[5]) le15++;
      if (!bus15_if.nOE[3]) noe15++;
      if (bus15_if.ACK[0]) begin ack15 = k; na15++; bus15_if.REQ = '0; end
    end
    n_cmp += 4;
    if (le1 != 1 || noe1 != 3) begin n_fail++; $display("FAIL le1_strobes got LE=%0d nOE=%0d want 1/3", le1, noe1); end
    if (ack1 != 4 || na1 != 1) begin n_fail++; $display("FAIL le1_ack got cyc=%0d count=%0d want 4/1", ack1, na1); end
    if (le15 != 15 || noe15 != 17) begin n_fail++; $display("FAIL le15_strobes got LE=%0d nOE=%0d want 15/17", le15, noe15); end
    if (ack15 != 18 || na15 != 1) begin n_fail++; $display("FAIL le15_ack got cyc=%0d count=%0d want 18/1", ack15, na15); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_error();
    test_input_change();
    test_reset_mid();
    test_le_cycles();
    tick();
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL final_pending got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
